adc_axis_capture_ctrl: RTL and testbench
========================================

Name: adc_axis_capture_ctrl

Overview:
- Capture controller/arbiter between two free-running ADC sample strobes and the single AXI4-Stream master datapath of the ADC_AXIS_M IP.
- Sequences captures (start/stop, frame count), round-robin-shares the stream between the two channels and frames the output with TLAST.
- Sits between the ADC front-end and the IP's M_AXIS port.
- Config and status connect to the IP's AXI-Lite register bank.

Parameters:
- SAMPLE_WIDTH, 16, ADC sample width; must be ≤ TDATA_WIDTH-1.
- TDATA_WIDTH, 32, m_axis_tdata width.
- CNT_WIDTH, 16, width of frame-length, frame-count and status counters.

Ports:
- aclk  in  1  single clock; all logic is on its rising edge.
- areset  in  1  reset, synchronous, active-high.
- adc0_data  in  SAMPLE_WIDTH  channel 0 sample.
- adc0_valid  in  1  channel 0 one-cycle strobe; no backpressure.
- adc1_data  in  SAMPLE_WIDTH  channel 1 sample.
- adc1_valid  in  1  channel 1 strobe.
- cfg_start  in  1  start pulse.
- cfg_stop  in  1  stop pulse.
- cfg_frame_len  in  CNT_WIDTH  beats per frame; 0 is treated as 1.
- cfg_num_frames  in  CNT_WIDTH  frames per capture; 0 means continuous.
- m_axis_tdata  out  TDATA_WIDTH  bit SAMPLE_WIDTH = channel id, [SAMPLE_WIDTH-1:0] = sample, other bits 0.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tuser  out  1  present only with the optional feature.
- sts_busy  out  1  high in CAPTURE or DRAIN.
- sts_done  out  1  one-cycle pulse when a capture ends.
- sts_overflow  out  1  sticky; a sample was dropped.
- sts_frame_cnt  out  CNT_WIDTH  frames completed in this capture.

Behaviour:
- Reset:
  - All outputs 0, FSM=IDLE, holding registers empty, round-robin pointer=ch0.
  - Reset asserted mid-capture discards any in-flight beat; tvalid drops in the next cycle.
- Holding register per channel, 1 entry:
  - A strobe with the register empty loads it.
  - A strobe with the register full sets sts_overflow and drops the new sample; the old sample is kept.
  - A strobe in the same cycle the register is unloaded loads the new sample, with no overflow.
  - Strobes are ignored outside CAPTURE and DRAIN.
- Output register:
  - Loads when (!tvalid || tready) and at least one holding register is full.
  - Grant goes to the channel not granted last if both are full; otherwise to the full one.
  - tdata, tlast and tuser are held stable while tvalid && !tready.
  - Latency from strobe to tvalid is 2 cycles when the output is idle.
- Counters:
  - beat_cnt increments on each handshake.
  - tlast=1 when beat_cnt == len_q-1.
  - A handshake with tlast set clears beat_cnt and increments sts_frame_cnt; it saturates at all-ones.
- FSM:
  - IDLE: cfg_start moves to CAPTURE; latches len_q and nfr_q; clears beat_cnt, sts_frame_cnt, sts_overflow, holding registers and the RR pointer.
  - CAPTURE, frame end: on a tlast handshake, if nfr_q!=0 and the new frame count == nfr_q, go to IDLE and pulse sts_done in the same cycle as the transition.
  - CAPTURE, stop: cfg_stop with beat_cnt==0 and tvalid=0 goes to IDLE, pulses sts_done and discards holding contents; otherwise go to DRAIN.
  - DRAIN: keep capturing until a tlast handshake, then go to IDLE and pulse sts_done. Beats that would start a new frame are not loaded.
  - cfg_start while not in IDLE is ignored.
  - cfg_start and cfg_stop in the same cycle in IDLE: start wins; stop is ignored.
  - cfg_* changes during a capture take no effect until the next start.

Optional Feature:
- Macro: ADC_CAPTURE_TUSER_SOF_EN.
- Defined: m_axis_tuser exists; it is 1 on the first beat of every frame (beat_cnt==0) and held stable with tdata.
- Undefined: the port is absent and no SOF logic is built.

Test Plan:
- Single channel, len=4, nfr=2, tready=1, adc0 strobe every 3 cycles with values 0x0001..0x0008:
  - 8 beats with tdata 0x00000001..0x00000008.
  - tlast on beats 4 and 8.
  - sts_done 1 cycle; sts_frame_cnt=2; sts_busy low after.
- Both channels strobe every cycle, 0xA000+ and 0xB000+, tready=1:
  - beats alternate ch0/ch1 (tdata[16] = 0,1,0,1…).
  - sts_overflow=1 after the first double-full collision.
- tready low for 5 cycles mid-frame:
  - tdata and tlast stay stable, with no beat lost or duplicated.
  - the overflow flag sets only if a strobe hits a full holding register.
- len=4, cfg_stop after beat 2:
  - DRAIN emits beats 3 and 4, tlast on 4, then sts_done.
  - stop with tvalid=0 at a frame boundary gives IDLE the next cycle with no further beats.
- len=0, nfr=0 (continuous): every beat has tlast=1; sts_frame_cnt counts up until cfg_stop.
- areset asserted mid-frame with tvalid=1: next cycle all outputs 0; a new cfg_start restarts with sts_frame_cnt=0 (with macro: tuser=1 on the first beat).

Source files
------------

// File: rtl/adc_axis_capture_ctrl.sv
// adc_axis_capture_ctrl: capture sequencer that merges two free-running ADC
// strobes into one AXI4-Stream master with frame framing (TLAST) and a
// frame-count-limited or continuous capture.
// Optional build macro: ADC_CAPTURE_TUSER_SOF_EN adds m_axis_tuser, a
// start-of-frame flag that travels with the first beat of each frame.
module adc_axis_capture_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int TDATA_WIDTH  = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [SAMPLE_WIDTH-1:0] adc0_data,
    input  logic                    adc0_valid,
    input  logic [SAMPLE_WIDTH-1:0] adc1_data,
    input  logic                    adc1_valid,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [CNT_WIDTH-1:0]    cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]    cfg_num_frames,
    output logic [TDATA_WIDTH-1:0]  m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
`ifdef ADC_CAPTURE_TUSER_SOF_EN
    output logic                    m_axis_tuser,
`endif
    input  logic                    m_axis_tready,
    output logic                    sts_busy,
    output logic                    sts_done,
    output logic                    sts_overflow,
    output logic [CNT_WIDTH-1:0]    sts_frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic                    busy, go_idle;

    logic [CNT_WIDTH-1:0]    len_q, nfr_q;
    logic [CNT_WIDTH-1:0]    beat_cnt_q, frame_cnt_q;
    logic                    rr_q;          // channel preferred when both are full
    logic                    ovf_q, done_q;

    logic [1:0]              hold_vld_q;
    logic [SAMPLE_WIDTH-1:0] hold_data_q [2];
    logic [SAMPLE_WIDTH-1:0] adc_data [2];
    logic [1:0]              strobe;

    logic                    tvalid_q, tlast_q;
    logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;

    logic [CNT_WIDTH-1:0]    len_eff, fc_inc, frames_now, next_idx;
    logic                    hs, hs_last, final_frame, starts_frame;
    logic                    drain_mode, load_block, load, grant;
    logic [1:0]              unload;
    logic                    clr, ovf_hit;

    assign adc_data[0] = adc0_data;
    assign adc_data[1] = adc1_data;
    assign strobe      = {adc1_valid, adc0_valid};

    // Datapath decisions: handshake, beat position of the next loaded beat, grant
    always_comb begin
        len_eff     = (len_q == '0) ? CNT_WIDTH'(1) : len_q;
        hs          = tvalid_q && m_axis_tready;
        hs_last     = hs && tlast_q;
        fc_inc      = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 1'b1;
        frames_now  = hs_last ? fc_inc : frame_cnt_q;
        final_frame = hs_last && (nfr_q != '0) && (fc_inc == nfr_q);
        // beat_cnt_q is the index of the beat sitting in the output register,
        // so the beat loaded now is one past it (or the same index if empty).
        next_idx = beat_cnt_q;
        if (tvalid_q)
            next_idx = tlast_q ? '0 : beat_cnt_q + 1'b1;
        starts_frame = (next_idx == '0);
        // Never open a frame that a stop or the frame limit would cut short.
        drain_mode = (state_q == S_DRAIN) || ((state_q == S_CAPTURE) && cfg_stop);
        load_block = starts_frame &&
                     (drain_mode || ((nfr_q != '0) && (frames_now == nfr_q)));
        grant  = (&hold_vld_q) ? rr_q : hold_vld_q[1];
        load   = busy && (!tvalid_q || m_axis_tready) && (|hold_vld_q) && !load_block;
        unload = load ? (grant ? 2'b10 : 2'b01) : 2'b00;
        tdata_d = '0;
        tdata_d[SAMPLE_WIDTH-1:0] = hold_data_q[grant];
        tdata_d[SAMPLE_WIDTH]     = grant;
        clr     = ((state_q == S_IDLE) && cfg_start) || go_idle;
        ovf_hit = busy && (|(strobe & hold_vld_q & ~unload));
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cfg_start) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (final_frame)
                    state_d = S_IDLE;
                else if (cfg_stop)
                    state_d = ((beat_cnt_q == '0) && !tvalid_q) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN:   if (hs_last || ((beat_cnt_q == '0) && !tvalid_q)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy    = (state_q != S_IDLE);
        go_idle = busy && (state_d == S_IDLE);
    end

    // Per-channel one-entry holding registers; a full register keeps its sample
    always_ff @(posedge aclk) begin
        if (areset || clr) begin
            hold_vld_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (strobe[c] && busy) begin
                    if (!hold_vld_q[c] || unload[c]) begin
                        hold_vld_q[c]  <= 1'b1;
                        hold_data_q[c] <= adc_data[c];
                    end
                end else if (unload[c]) begin
                    hold_vld_q[c] <= 1'b0;
                end
            end
        end
    end

    // AXIS output register; contents frozen while stalled
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            tlast_q  <= (next_idx == len_eff - 1'b1);
            tdata_q  <= tdata_d;
        end else if (hs) begin
            tvalid_q <= 1'b0;
        end
    end

    // Capture config latch, beat/frame counters, RR pointer and status flags
    always_ff @(posedge aclk) begin
        if (areset) begin
            len_q       <= '0;
            nfr_q       <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            rr_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= go_idle;
            if ((state_q == S_IDLE) && cfg_start) begin
                len_q       <= cfg_frame_len;
                nfr_q       <= cfg_num_frames;
                beat_cnt_q  <= '0;
                frame_cnt_q <= '0;
                rr_q        <= 1'b0;
                ovf_q       <= 1'b0;
            end else begin
                if (hs) begin
                    if (tlast_q) begin
                        beat_cnt_q  <= '0;
                        frame_cnt_q <= fc_inc;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                if (load)    rr_q  <= ~grant;
                if (ovf_hit) ovf_q <= 1'b1;
            end
        end
    end

`ifdef ADC_CAPTURE_TUSER_SOF_EN
    logic tuser_q;

    // SOF flag is captured with the beat it marks and held with tdata
    always_ff @(posedge aclk) begin
        if (areset)    tuser_q <= 1'b0;
        else if (load) tuser_q <= starts_frame;
    end

    assign m_axis_tuser = tuser_q;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_busy      = busy;
    assign sts_done      = done_q;
    assign sts_overflow  = ovf_q;
    assign sts_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_axis_capture_ctrl.sv
// Bench for adc_axis_capture_ctrl: directed scenarios plus a random phase,
// every cycle compared against a queue-based behavioural model.
module tb_adc_axis_capture_ctrl;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset, cfg_start, cfg_stop, adc0_valid, adc1_valid, m_axis_tready;
    logic [15:0] adc0_data, adc1_data, cfg_frame_len, cfg_num_frames;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, sts_busy, sts_done, sts_overflow;
    logic [15:0] sts_frame_cnt;
`ifdef ADC_CAPTURE_TUSER_SOF_EN
    logic        m_axis_tuser;
`endif

    adc_axis_capture_ctrl dut (
        .aclk(aclk), .areset(areset),
        .adc0_data(adc0_data), .adc0_valid(adc0_valid),
        .adc1_data(adc1_data), .adc1_valid(adc1_valid),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
`ifdef ADC_CAPTURE_TUSER_SOF_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .m_axis_tready(m_axis_tready),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_overflow(sts_overflow),
        .sts_frame_cnt(sts_frame_cnt)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic ch; logic [15:0] d; logic last; logic sof; } beat_t;
    beat_t       oq[$];             // beat presented on the stream (0 or 1)
    logic [15:0] hq0[$], hq1[$];    // per-channel pending sample (0 or 1)
    int          mst = 0;           // 0 idle, 1 capturing, 2 draining
    int          nbeats = 0, nload = 0, mlen = 1, mnfr = 0;
    bit          mpref = 0, movf = 0, mdone = 0;

    task automatic m_idle();
        mst = 0; mdone = 1;
        hq0.delete(); hq1.delete(); oq.delete();
    endtask

    task automatic model_step();
        bit    pre_empty, pre_bnd, hs, fdone, fin, drn, ld, g;
        beat_t b;
        mdone = 0;
        if (areset) begin
            mst = 0; oq.delete(); hq0.delete(); hq1.delete();
            nbeats = 0; nload = 0; movf = 0; mpref = 0;
            return;
        end
        if (mst == 0) begin
            if (cfg_start) begin
                mst = 1; mlen = (cfg_frame_len == 0) ? 1 : int'(cfg_frame_len);
                mnfr = int'(cfg_num_frames);
                nbeats = 0; nload = 0; movf = 0; mpref = 0;
                hq0.delete(); hq1.delete();
            end
            return;
        end
        pre_empty = (oq.size() == 0);
        pre_bnd   = (nbeats % mlen == 0);
        hs        = !pre_empty && m_axis_tready;
        if (hs) begin oq.delete(0); nbeats++; end
        fdone = hs && (nbeats % mlen == 0);
        fin   = fdone && (mnfr != 0) && (nbeats / mlen == mnfr);
        drn   = (mst == 2) || cfg_stop;
        ld    = (oq.size() == 0) && (hq0.size() != 0 || hq1.size() != 0);
        if (nload % mlen == 0 && (drn || (mnfr != 0 && nload / mlen >= mnfr))) ld = 0;
        if (ld) begin
            g = (hq0.size() != 0 && hq1.size() != 0) ? mpref : (hq1.size() != 0);
            b.ch = g; b.d = g ? hq1[0] : hq0[0];
            b.last = (nload % mlen == mlen - 1); b.sof = (nload % mlen == 0);
            oq.push_back(b); nload++; mpref = !g;
            if (g) hq1.delete(0); else hq0.delete(0);
        end
        if (adc0_valid) begin if (hq0.size() == 0) hq0.push_back(adc0_data); else movf = 1; end
        if (adc1_valid) begin if (hq1.size() == 0) hq1.push_back(adc1_data); else movf = 1; end
        if (mst == 1) begin
            if (fin) m_idle();
            else if (cfg_stop) begin
                if (pre_empty && pre_bnd) m_idle(); else mst = 2;
            end
        end else if (fdone || (pre_empty && pre_bnd)) begin
            m_idle();
        end
    endtask

    task automatic compare();
        int f;
        f = nbeats / mlen;
        if (f > 65535) f = 65535;
        chk("tvalid", 32'(m_axis_tvalid), 32'(oq.size() != 0));
        if (oq.size() != 0) begin
            chk("tdata", m_axis_tdata, 32'({oq[0].ch, oq[0].d}));
            chk("tlast", 32'(m_axis_tlast), 32'(oq[0].last));
`ifdef ADC_CAPTURE_TUSER_SOF_EN
            chk("tuser", 32'(m_axis_tuser), 32'(oq[0].sof));
`endif
        end
        chk("busy", 32'(sts_busy), 32'(mst != 0));
        chk("done", 32'(sts_done), 32'(mdone));
        chk("overflow", 32'(sts_overflow), 32'(movf));
        chk("frame_cnt", 32'(sts_frame_cnt), 32'(f));
    endtask

    // ---------------- per-cycle driver ----------------
    logic [31:0] seen_q[$];
    int          hs_seen = 0, last_seen = 0, done_seen = 0;

    task automatic clr_cnt();
        seen_q.delete(); hs_seen = 0; last_seen = 0; done_seen = 0;
    endtask

    task automatic step();
        if (m_axis_tvalid && m_axis_tready) begin
            seen_q.push_back(m_axis_tdata); hs_seen++;
            if (m_axis_tlast) last_seen++;
        end
        @(posedge aclk);
        model_step();
        #1;
        compare();
        if (sts_done) done_seen++;
        areset = 0; cfg_start = 0; cfg_stop = 0; adc0_valid = 0; adc1_valid = 0;
    endtask

    task automatic start(input int len, input int nfr);
        cfg_frame_len = 16'(len); cfg_num_frames = 16'(nfr); cfg_start = 1;
        step();
        clr_cnt();
    endtask

    initial begin
        areset = 1; cfg_start = 0; cfg_stop = 0; adc0_valid = 0; adc1_valid = 0;
        adc0_data = 0; adc1_data = 0; cfg_frame_len = 0; cfg_num_frames = 0;
        m_axis_tready = 1;
        step(); areset = 1; step(); step();

        // A: single channel, len 4, two frames
        start(4, 2);
        for (int i = 1; i <= 8; i++) begin
            adc0_valid = 1; adc0_data = 16'(i); step(); step(); step();
        end
        repeat (6) step();
        chk("A_beats", 32'(hs_seen), 32'd8);
        chk("A_lasts", 32'(last_seen), 32'd2);
        chk("A_done", 32'(done_seen), 32'd1);
        chk("A_busy", 32'(sts_busy), 32'd0);
        chk("A_fc", 32'(sts_frame_cnt), 32'd2);
        for (int i = 0; i < seen_q.size(); i++) chk("A_data", seen_q[i], 32'(i + 1));

        // B: both channels every cycle, stop then drain with strobes running
        start(4, 0);
        for (int i = 0; i < 32; i++) begin
            adc0_valid = 1; adc0_data = 16'(16'hA000 + i);
            adc1_valid = 1; adc1_data = 16'(16'hB000 + i);
            cfg_stop = (i == 20);
            step();
        end
        repeat (3) step();
        chk("B_ovf", 32'(sts_overflow), 32'd1);
        chk("B_busy", 32'(sts_busy), 32'd0);
        for (int i = 0; i < seen_q.size(); i++) chk("B_alt", 32'(seen_q[i][16]), 32'(i & 1));

        // C: tready stall mid-frame, one frame of 8
        start(8, 1);
        for (int i = 0; i < 40; i++) begin
            adc0_valid = (i % 2 == 0) && (i < 32); adc0_data = 16'(i + 1);
            m_axis_tready = !(i >= 8 && i < 13);
            step();
        end
        m_axis_tready = 1;
        chk("C_beats", 32'(hs_seen), 32'd8);
        for (int i = 1; i < seen_q.size(); i++) chk("C_order", 32'(seen_q[i] > seen_q[i-1]), 32'd1);

        // D: stop after beat 2 drains beats 3 and 4
        start(4, 0);
        for (int i = 0; i < 60 && hs_seen < 2; i++) begin
            adc0_valid = (i % 2 == 0); adc0_data = 16'(16'h0100 + i); step();
        end
        chk("D_reach2", 32'(hs_seen), 32'd2);
        for (int i = 0; i < 20; i++) begin
            cfg_stop = (i == 0); adc0_valid = (i % 2 == 0); adc0_data = 16'(16'h0200 + i);
            step();
        end
        chk("D_beats", 32'(hs_seen), 32'd4);
        chk("D_lasts", 32'(last_seen), 32'd1);
        chk("D_done", 32'(done_seen), 32'd1);

        // D2: stop at a frame boundary with the output idle
        start(4, 0);
        for (int i = 0; i < 8; i++) begin adc0_valid = (i % 2 == 0); adc0_data = 16'(i); step(); end
        repeat (4) step();
        chk("D2_beats", 32'(hs_seen), 32'd4);
        cfg_stop = 1; step();
        chk("D2_idle", 32'(sts_busy), 32'd0);
        chk("D2_done", 32'(sts_done), 32'd1);
        repeat (3) step();
        chk("D2_nomore", 32'(hs_seen), 32'd4);

        // E: len 0, continuous: every beat is a frame
        start(0, 0);
        for (int i = 0; i < 12; i++) begin adc1_valid = (i % 2 == 0); adc1_data = 16'(16'h0C00 + i); step(); end
        repeat (4) step();
        chk("E_fc", 32'(sts_frame_cnt), 32'd6);
        chk("E_lasts", 32'(last_seen), 32'd6);
        cfg_stop = 1; step(); step();
        chk("E_busy", 32'(sts_busy), 32'd0);

        // F: reset mid-frame, then restart
        start(4, 0);
        for (int i = 0; i < 6; i++) begin adc0_valid = 1; adc0_data = 16'(16'h0F00 + i); step(); end
        chk("F_pre_valid", 32'(m_axis_tvalid), 32'd1);
        areset = 1; step();
        chk("F_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("F_tdata", m_axis_tdata, 32'd0);
        chk("F_tlast", 32'(m_axis_tlast), 32'd0);
        chk("F_fc", 32'(sts_frame_cnt), 32'd0);
        start(4, 1);
        for (int i = 0; i < 16; i++) begin adc1_valid = (i < 10); adc1_data = 16'(16'h0E00 + i); step(); end
        chk("F_restart_fc", 32'(sts_frame_cnt), 32'd1);

        // G: random traffic, config churn, stalls, stops and resets
        for (int i = 0; i < 3000; i++) begin
            cfg_frame_len  = 16'($urandom_range(0, 5));
            cfg_num_frames = 16'($urandom_range(0, 3));
            m_axis_tready  = ($urandom_range(0, 3) != 0);
            adc0_valid = ($urandom_range(0, 1) == 1); adc0_data = 16'($urandom);
            adc1_valid = ($urandom_range(0, 2) == 0); adc1_data = 16'($urandom);
            cfg_start = ($urandom_range(0, 15) == 0);
            cfg_stop  = ($urandom_range(0, 40) == 0);
            areset    = ($urandom_range(0, 700) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
